// File: rtl/lifo_fifo_buf_if.sv
// Bundle of producer/consumer signals for lifo_fifo_buf.
//
// Handshake: there is no back-pressure. A write is a single-cycle wr_en strobe
// with data_in sampled on the same rising edge; a read is a single-cycle rd_en
// strobe, answered after that edge by data_out qualified with a one-cycle
// valid_out pulse. A strobe the buffer cannot honour is dropped, and the
// matching overflow/underflow pulse reports it. count and the empty/full/almost
// flags are the caller's way of avoiding dropped strobes.
interface lifo_fifo_buf_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
);
   localparam int CW = $clog2(DEPTH + 1);

   logic             mode;
   logic             wr_en;
   logic [WIDTH-1:0] data_in;
   logic             rd_en;
   logic [WIDTH-1:0] data_out;
   logic             valid_out;
   logic [CW-1:0]    count;
   logic             empty;
   logic             full;
   logic             almost_empty;
   logic             almost_full;
   logic             overflow;
   logic             underflow;

   // Producer/consumer side.
   modport master (
      output mode, wr_en, data_in, rd_en,
      input  data_out, valid_out, count, empty, full,
             almost_empty, almost_full, overflow, underflow
   );

   // Buffer side.
   modport slave (
      input  mode, wr_en, data_in, rd_en,
      output data_out, valid_out, count, empty, full,
             almost_empty, almost_full, overflow, underflow
   );
endinterface

// File: rtl/lifo_fifo_buf.sv
// Register-array buffer with LIFO or FIFO ordering selected while empty.
// The storage is used circularly in both modes: FIFO reads at rd_ptr and
// writes at wr_ptr; LIFO treats the entry just below wr_ptr as the stack top.
// Because the stack is circular too, it works from whatever pointer position
// the previous mode left behind, so no pointer reset is needed on a mode swap.
module lifo_fifo_buf #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 16,
   parameter int AFULL_TH  = DEPTH - 2,
   parameter int AEMPTY_TH = 2
) (
   input logic            clk,
   input logic            rst,
   lifo_fifo_buf_if.slave bus
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];

   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW-1:0]    wr_ptr_nxt, rd_ptr_nxt;
   logic [AW-1:0]    top_ptr, rd_addr, wr_addr;
   logic [CW-1:0]    count_q, count_nxt;
   logic             mode_q;
   logic [WIDTH-1:0] data_q;
   logic             valid_q, ovf_q, udf_q;
   logic             is_empty, is_full;
   logic             rd_acc, wr_acc;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + AW'(1);
   endfunction

   function automatic logic [AW-1:0] ptr_dec(input logic [AW-1:0] p);
      return (p == '0) ? LAST_PTR : p - AW'(1);
   endfunction

   assign is_empty = (count_q == '0);
   assign is_full  = (count_q == FULL_CNT);

   // Accept/reject decisions, addresses and next pointer/count values.
   always_comb begin
      top_ptr    = ptr_dec(wr_ptr);
      rd_acc     = bus.rd_en && !is_empty;
      wr_acc     = bus.wr_en && (!is_full || rd_acc);
      rd_addr    = mode_q ? rd_ptr : top_ptr;
      wr_addr    = wr_ptr;
      wr_ptr_nxt = wr_ptr;
      rd_ptr_nxt = rd_ptr;
      count_nxt  = count_q;

      if (!mode_q) begin
         // LIFO: a combined read/write swaps the top in place.
         if (wr_acc && rd_acc) begin
            wr_addr = top_ptr;
         end else if (wr_acc) begin
            wr_ptr_nxt = ptr_inc(wr_ptr);
         end else if (rd_acc) begin
            wr_ptr_nxt = top_ptr;
         end
      end else begin
         if (wr_acc) wr_ptr_nxt = ptr_inc(wr_ptr);
         if (rd_acc) rd_ptr_nxt = ptr_inc(rd_ptr);
      end

      // When empty, the oldest entry is wherever the next write lands; keeping
      // rd_ptr aligned here makes a switch into FIFO mode start consistently.
      if (is_empty) rd_ptr_nxt = wr_ptr;

      if (wr_acc && !rd_acc) begin
         count_nxt = count_q + CW'(1);
      end else if (rd_acc && !wr_acc) begin
         count_nxt = count_q - CW'(1);
      end
   end

   // Control state, read data and one-cycle status pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         mode_q  <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         count_q <= count_nxt;
         wr_ptr  <= wr_ptr_nxt;
         rd_ptr  <= rd_ptr_nxt;
         if (is_empty) mode_q <= bus.mode;
         if (rd_acc) data_q <= mem[rd_addr];
         valid_q <= rd_acc;
         ovf_q   <= bus.wr_en && !wr_acc;
         udf_q   <= bus.rd_en && is_empty;
      end
   end

   // Storage array; contents survive reset by design.
   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_addr] <= bus.data_in;
   end

   assign bus.data_out     = data_q;
   assign bus.valid_out    = valid_q;
   assign bus.overflow     = ovf_q;
   assign bus.underflow    = udf_q;
   assign bus.count        = count_q;
   assign bus.empty        = is_empty;
   assign bus.full         = is_full;
   assign bus.almost_full  = (int'(count_q) >= AFULL_TH);
   assign bus.almost_empty = (int'(count_q) <= AEMPTY_TH);

endmodule

// File: tb/tb_lifo_fifo_buf.sv
// Bench for lifo_fifo_buf: directed scenarios followed by random traffic,
// all compared against a queue-based ordering model.
module tb_lifo_fifo_buf;

   localparam int W     = 8;
   localparam int DEPTH = 16;
   localparam int AF_TH = DEPTH - 2;
   localparam int AE_TH = 2;

   logic clk;
   logic rst;

   lifo_fifo_buf_if #(.WIDTH(W), .DEPTH(DEPTH)) bus ();

   lifo_fifo_buf #(
      .WIDTH(W), .DEPTH(DEPTH), .AFULL_TH(AF_TH), .AEMPTY_TH(AE_TH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Clock and watchdog.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model state.
   logic [W-1:0] exp_q[$];
   logic         m_mode;
   logic [W-1:0] e_data;
   logic         e_valid, e_ovf, e_udf;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_mode  = 1'b0;
      e_data  = '0;
      e_valid = 1'b0;
      e_ovf   = 1'b0;
      e_udf   = 1'b0;
   endtask

   // Effect of one rising edge on the ordered contents.
   task automatic model_edge(input logic w, input logic [W-1:0] d, input logic r, input logic m);
      int sz;
      bit ra, wa;
      sz = exp_q.size();
      if (sz == 0) m_mode = m;
      ra = r && (sz > 0);
      wa = w && ((sz < DEPTH) || ra);
      e_valid = ra;
      e_udf   = r && (sz == 0);
      e_ovf   = w && !wa;
      if (ra) begin
         if (m_mode) e_data = exp_q.pop_front();
         else        e_data = exp_q.pop_back();
      end
      if (wa) exp_q.push_back(d);
   endtask

   task automatic compare_all();
      int sz;
      sz = exp_q.size();
      check("data_out",     32'(bus.data_out),     32'(e_data));
      check("valid_out",    32'(bus.valid_out),    32'(e_valid));
      check("overflow",     32'(bus.overflow),     32'(e_ovf));
      check("underflow",    32'(bus.underflow),    32'(e_udf));
      check("count",        32'(bus.count),        32'(sz));
      check("empty",        32'(bus.empty),        32'(sz == 0));
      check("full",         32'(bus.full),         32'(sz == DEPTH));
      check("almost_empty", 32'(bus.almost_empty), 32'(sz <= AE_TH));
      check("almost_full",  32'(bus.almost_full),  32'(sz >= AF_TH));
   endtask

   // Driver: one cycle of strobes, then compare just after the edge.
   task automatic drive(input logic w, input logic [W-1:0] d, input logic r, input logic m);
      @(negedge clk);
      bus.wr_en   = w;
      bus.data_in = d;
      bus.rd_en   = r;
      bus.mode    = m;
      model_edge(w, d, r, m);
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic idle_strobes();
      bus.wr_en   = 1'b0;
      bus.rd_en   = 1'b0;
      bus.data_in = '0;
   endtask

   initial begin
      int pw, pr;
      logic rm;
      rst = 1'b1;
      bus.mode = 1'b0;
      idle_strobes();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all();
      @(negedge clk);
      rst = 1'b0;

      // LIFO fill, overflow, drain.
      for (int i = 1; i <= DEPTH; i++) drive(1'b1, W'(i), 1'b0, 1'b0);
      check("lifo_full_count", 32'(bus.count), 32'd16);
      drive(1'b1, 8'hEE, 1'b0, 1'b0);
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      check("ovf_prev_top", 32'(bus.data_out), 32'h10);
      for (int i = 0; i < DEPTH - 1; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
      check("lifo_last", 32'(bus.data_out), 32'h01);
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      check("udf_hold", 32'(bus.data_out), 32'h01);

      // FIFO order and pointer wrap.
      for (int i = 0; i < 10; i++) drive(1'b1, W'(8'hA0 + i), 1'b0, 1'b1);
      for (int i = 0; i < 5; i++)  drive(1'b0, 8'h00, 1'b1, 1'b1);
      check("fifo_a4", 32'(bus.data_out), 32'hA4);
      for (int i = 0; i < 10; i++) drive(1'b1, W'(8'hB0 + i), 1'b0, 1'b1);
      for (int i = 0; i < 15; i++) drive(1'b0, 8'h00, 1'b1, 1'b1);
      check("fifo_b9", 32'(bus.data_out), 32'hB9);

      // Full FIFO with simultaneous strobes, then drain.
      for (int i = 0; i < DEPTH; i++) drive(1'b1, W'(8'hC0 + i), 1'b0, 1'b1);
      drive(1'b1, 8'h77, 1'b1, 1'b1);
      check("fifo_full_rw", 32'(bus.data_out), 32'hC0);
      for (int i = 0; i < DEPTH; i++) drive(1'b0, 8'h00, 1'b1, 1'b1);

      // Empty with both strobes: underflow yet write lands.
      drive(1'b1, 8'h55, 1'b1, 1'b1);
      drive(1'b0, 8'h00, 1'b1, 1'b1);

      // LIFO simultaneous swap of the top.
      drive(1'b1, 8'h11, 1'b0, 1'b0);
      drive(1'b1, 8'h22, 1'b0, 1'b0);
      drive(1'b1, 8'h33, 1'b1, 1'b0);
      check("lifo_rw_out", 32'(bus.data_out), 32'h22);
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      check("lifo_rw_new", 32'(bus.data_out), 32'h33);
      drive(1'b0, 8'h00, 1'b1, 1'b0);

      // Mode lock: request FIFO while LIFO holds data.
      for (int i = 0; i < 3; i++) drive(1'b1, W'(8'h61 + i), 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 1'b1, 1'b1);
      check("lock_last", 32'(bus.data_out), 32'h61);
      for (int i = 0; i < 3; i++) drive(1'b1, W'(8'h71 + i), 1'b0, 1'b1);
      drive(1'b0, 8'h00, 1'b1, 1'b1);
      check("lock_fifo", 32'(bus.data_out), 32'h71);
      drive(1'b0, 8'h00, 1'b1, 1'b1);
      drive(1'b0, 8'h00, 1'b1, 1'b1);

      // Asynchronous reset between edges at count 7.
      for (int i = 0; i < 7; i++) drive(1'b1, W'(8'h90 + i), 1'b0, 1'b0);
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      drive(1'b1, 8'h97, 1'b0, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      compare_all();
      @(negedge clk);
      idle_strobes();
      @(negedge clk);
      rst = 1'b0;
      drive(1'b0, 8'h00, 1'b1, 1'b0);

      // Random traffic in phases of different write/read bias.
      rm = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         case ((i / 100) % 3)
            0:       begin pw = 80; pr = 30; end
            1:       begin pw = 30; pr = 80; end
            default: begin pw = 60; pr = 60; end
         endcase
         if ($urandom_range(0, 19) == 0) rm = ~rm;
         drive(1'($urandom_range(0, 99) < pw), W'($urandom),
               1'($urandom_range(0, 99) < pr), rm);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lifo_fifo_buf.md
# lifo_fifo_buf

Parametrised, synthesizable data buffer with run-time selectable LIFO (stack) or FIFO (queue) ordering, fixed-size register storage, occupancy count, programmable almost-full/almost-empty thresholds, and sticky-free overflow/underflow pulses. It is the next generation of the team's 16x8 LIFO and sits between a producer and a consumer on the same clock. Both sides use a single-cycle `wr_en`/`rd_en` strobe, and read data is returned one cycle later with a `valid_out` qualifier.

## Interface
- `WIDTH`, 8: data width in bits (>=1).
- `DEPTH`, 16: number of entries (>=2; need not be a power of two).
- `AFULL_TH`, DEPTH-2: `almost_full` asserts when count >= AFULL_TH.
- `AEMPTY_TH`, 2: `almost_empty` asserts when count <= AEMPTY_TH.

- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `mode`, in, 1: requested ordering, 0 = LIFO, 1 = FIFO. It takes effect only while the buffer is empty.
- `wr_en`, in, 1: write strobe.
- `data_in`, in, WIDTH: write data.
- `rd_en`, in, 1: read strobe.
- `data_out`, out, WIDTH: registered read data.
- `valid_out`, out, 1: one-cycle pulse marking new `data_out`.
- `count`, out, $clog2(DEPTH+1): current occupancy.
- `empty`, `full`, out, 1: count==0 / count==DEPTH.
- `almost_empty`, `almost_full`, out, 1: threshold flags.
- `overflow`, out, 1: one-cycle pulse, write dropped because full.
- `underflow`, out, 1: one-cycle pulse, read rejected because empty.

## Operation
- **Active mode register `mode_q`.** Loads `mode` on every edge where count==0 before the edge. While count>0, changes on `mode` are ignored.
- **Storage.** DEPTH x WIDTH register array plus read/write pointers.
  - Pointers wrap from DEPTH-1 to 0 in FIFO mode.
  - LIFO uses the write pointer as the stack top.
  - Memory contents are not reset.
- **Write accepted** when `wr_en` && (!full || read accepted in the same cycle). A write with `wr_en` && full && no accepted read is dropped, and `overflow` pulses.
- **Read accepted** when `rd_en` && !empty. A read with `rd_en` && empty is rejected, and `underflow` pulses. A write in the same cycle is still accepted.
- **LIFO read** returns the most recent stored entry (the top). **FIFO read** returns the oldest entry.
- **Simultaneous accepted read and write:**
  - count unchanged.
  - LIFO: `data_out` gets the old top, and `data_in` replaces it as the new top.
  - FIFO: `data_out` gets the oldest entry, and `data_in` is appended; this also applies when full.
- **Count update:**
  - write-only: +1
  - read-only: -1
  - both, or neither: unchanged
- **`data_out` hold.** `data_out` holds its last value when no read is accepted.

## Timing
- **Reset values**, applied asynchronously the instant `rst` rises:
  - count=0, pointers=0, `mode_q`=0 (LIFO)
  - `data_out`=0, `valid_out`=0, `overflow`=0, `underflow`=0
  - `empty`=1, `full`=0, `almost_empty`=1
  - `almost_full`=(AFULL_TH==0)
- **Reset mid-operation.** All in-flight strobes are discarded. The first edge after `rst` falls behaves as if starting from empty.
- **Read latency.** 1 cycle: `rd_en` sampled at edge N gives `data_out` and `valid_out` after edge N.
- **Error pulses.** `valid_out`, `overflow` and `underflow` are registered and high for exactly one cycle per offending edge.
- **Status flags.** `count`, `empty`, `full`, `almost_*` are registered, or combinational from registered count only. They reflect the state after the most recent edge.
- **Throughput.** One write and/or one read per cycle, sustained.
- **Mode change.** A `mode` change requested while non-empty takes effect at the first edge at which count==0 before the edge.

## Test plan
- **LIFO fill/drain.** Reset, mode=0, write 0x01..0x10 (DEPTH=16) -> `full`=1 and count=16 after the 16th edge, `almost_full` from count=14. Then 16 reads -> `data_out` sequence 0x10,0x0F..0x01, each with a `valid_out` pulse, `empty`=1 at the end.
- **FIFO order and wrap.** mode=1, write 0xA0..0xA9, read 5 (0xA0..0xA4), write 0xB0..0xB9 (count 15), read 15 -> 0xA5..0xA9 then 0xB0..0xB9.
- **Overflow/underflow.**
  - Full LIFO plus `wr_en`=1 with data 0xEE -> `overflow` pulses once, count stays 16, and the next read returns the previous top (not 0xEE).
  - Empty buffer plus `rd_en` -> `underflow` pulses, `valid_out`=0, `data_out` unchanged.
- **Simultaneous read/write.**
  - LIFO holding 0x11,0x22 (top 0x22), both strobes with 0x33 -> `data_out`=0x22, count=2, next read returns 0x33.
  - Full FIFO, both strobes -> oldest entry out, count stays 16, no `overflow`.
  - Empty, both strobes -> `underflow` pulses, write accepted, count=1.
- **Mode lock.** LIFO holding 3 entries, drive mode=1 -> reads still come out LIFO. After the buffer drains, the next writes/reads follow FIFO order.
- **Async reset mid-stream.** Assert `rst` between edges while count=7 -> count=0, `empty`=1, `data_out`=0 immediately, without waiting for a clock edge. After release, the first read gives `underflow`.
